// File: rtl/cursor_pkg.sv
// cursor_pkg: shared state encoding and packet constants for the cursor transmit scheduler
package cursor_pkg;
   typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;
   localparam int PKT_MAX = 127;
   localparam int PKT_MIN = -127;
   localparam int UART_BITS_PER_BYTE = 10;
   localparam int PKT_BYTES = 5;
   function automatic int max_int(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/cursor_sat_accum.sv
// cursor_sat_accum: one-axis saturating motion accumulator with packet-range clamp of its next value
module cursor_sat_accum import cursor_pkg::*; #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             add_en,
   input  logic [ACC_W-1:0] add,
   input  logic             sub_en,
   input  logic [7:0]       sub,
   output logic [ACC_W-1:0] acc,
   output logic [7:0]       clamped,
   output logic             sat
);
   localparam logic signed [ACC_W+1:0] LIM = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+1:0] NLIM = -LIM;
   localparam logic signed [ACC_W-1:0] PMAX = ACC_W'(PKT_MAX);
   localparam logic signed [ACC_W-1:0] PMIN = ACC_W'(PKT_MIN);
   logic signed [ACC_W+1:0] sum;
   logic signed [ACC_W-1:0] acc_n;
   // subtract-emitted and add-new happen in one update so a delta in the SEND cycle is never lost
   always_comb begin
      sum = $signed({{2{acc[ACC_W-1]}}, acc})
          + (add_en ? $signed({{2{add[ACC_W-1]}}, add}) : '0)
          - (sub_en ? $signed({{(ACC_W-6){sub[7]}}, sub}) : '0);
      sat = sum > LIM || sum < NLIM;
      acc_n = sum > LIM ? LIM[ACC_W-1:0] : sum < NLIM ? NLIM[ACC_W-1:0] : sum[ACC_W-1:0];
      clamped = acc_n > PMAX ? PMAX[7:0] : acc_n < PMIN ? PMIN[7:0] : acc_n[7:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) acc <= '0;
      else acc <= acc_n;
endmodule

// File: rtl/cursor_tx_scheduler.sv
// cursor_tx_scheduler: paces cursor motion/button packets to the UART transmitter, carrying residual motion.
// Optional CURSOR_KEEPALIVE_EN: a zero-motion packet is forced after KEEPALIVE_CYCLES idle cycles.
module cursor_tx_scheduler import cursor_pkg::*; #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FRAME_CYCLES = PKT_BYTES * UART_BITS_PER_BYTE * (CLKS_PER_BIT + 1) + 64,
   parameter int GAP_CYCLES = 250000,
   parameter int ACC_W = 16,
   parameter int KEEPALIVE_CYCLES = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        in_valid,
   input  logic [15:0] in_dx,
   input  logic [15:0] in_dy,
   input  logic [1:0]  in_buttons,
   output logic        send,
   output logic [1:0]  buttons,
   output logic [7:0]  dx,
   output logic [7:0]  dy,
   output logic        busy,
   output logic        sat_flag
);
   localparam int HOLD_LOAD = max_int(FRAME_CYCLES, GAP_CYCLES) - 2;
   localparam int CW = $clog2(max_int(HOLD_LOAD, KEEPALIVE_CYCLES) + 1);
   state_t state, next;
   logic [CW-1:0] timer;
   logic [ACC_W-1:0] acc_x, acc_y;
   logic [7:0] cx, cy;
   logic sx, sy, pending, ka_fire, go, in_send;
   logic [1:0] last_btn;

   assign in_send = state == SEND;
   assign send = in_send;
   assign busy = state != IDLE;
   assign pending = acc_x != '0 || acc_y != '0 || in_buttons != last_btn;
   assign go = state == IDLE && enable && (pending || ka_fire);

   cursor_sat_accum #(.ACC_W(ACC_W)) u_acc_x (
      .clk, .rst, .add_en(in_valid), .add(in_dx), .sub_en(in_send), .sub(dx),
      .acc(acc_x), .clamped(cx), .sat(sx));
   cursor_sat_accum #(.ACC_W(ACC_W)) u_acc_y (
      .clk, .rst, .add_en(in_valid), .add(in_dy), .sub_en(in_send), .sub(dy),
      .acc(acc_y), .clamped(cy), .sat(sy));

`ifdef CURSOR_KEEPALIVE_EN
   logic [CW-1:0] ka_cnt;
   assign ka_fire = state == IDLE && !pending && ka_cnt >= CW'(KEEPALIVE_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) ka_cnt <= '0;
      else if (in_send) ka_cnt <= '0;
      else if (state == IDLE && !pending && !ka_fire) ka_cnt <= ka_cnt + 1'b1;
`else
   assign ka_fire = 1'b0;
`endif

   // HOLD leaves one cycle early so the next SEND lands exactly one packet period later
   always_comb begin
      next = state;
      next = state == IDLE ? (go ? SEND : IDLE) : state == SEND ? HOLD : (timer <= CW'(1) ? IDLE : HOLD);
   end

   // packet fields are captured on entry to SEND; the accumulators subtract them during SEND
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         last_btn <= '0;
         dx <= '0;
         dy <= '0;
         buttons <= '0;
         sat_flag <= 1'b0;
      end else begin
         state <= next;
         timer <= in_send ? CW'(HOLD_LOAD) : state == HOLD ? timer - 1'b1 : timer;
         sat_flag <= sat_flag | sx | sy;
         if (go) begin
            dx <= pending ? cx : '0;
            dy <= pending ? cy : '0;
            buttons <= in_buttons;
            last_btn <= in_buttons;
         end
      end
endmodule

// File: tb/tb_cursor_tx_scheduler.sv
// tb_cursor_tx_scheduler: randomized scoreboard bench against a packet-level reference model
module tb_cursor_tx_scheduler;
   localparam int M = 100;
   localparam int KA = 400;
   logic clk = 0, rst = 1, enable = 0, in_valid = 0;
   logic [15:0] in_dx = '0, in_dy = '0;
   logic [1:0] in_buttons = '0;
   logic send, busy, sat_flag;
   logic [1:0] buttons;
   logic [7:0] dx, dy;

   cursor_tx_scheduler #(.CLKS_PER_BIT(1), .FRAME_CYCLES(M), .GAP_CYCLES(M), .ACC_W(16),
                         .KEEPALIVE_CYCLES(KA)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_dx(in_dx), .in_dy(in_dy),
      .in_buttons(in_buttons), .send(send), .buttons(buttons), .dx(dx), .dy(dy),
      .busy(busy), .sat_flag(sat_flag));

   always #5 clk = ~clk;

   typedef struct {int cyc; int dx; int dy; int btn;} pkt_t;
   pkt_t q[$];
   int nchk = 0, npass = 0, cyc = 0;
   int m_ax = 0, m_ay = 0, m_btn = 0, m_ls = -1000000, m_ka = 0, o_dx = 0, o_dy = 0, o_btn = 0;
   bit m_sat = 0;

   function automatic int sat16(int v);
      return v > 32767 ? 32767 : v < -32767 ? -32767 : v;
   endfunction
   function automatic int clamp8(int v);
      return v > 127 ? 127 : v < -127 ? -127 : v;
   endfunction
   function automatic int rnd_delta();
      case ($urandom_range(0, 9))
         0, 1, 2, 3, 4, 5: return int'($urandom_range(0, 40)) - 20;
         6, 7: return int'($urandom_range(0, 1000)) - 500;
         8: return int'($urandom_range(0, 60000)) - 30000;
         default: return $urandom_range(0, 1) == 1 ? 32767 : -32768;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
   endtask

   // reference model: packet rules applied once per clock edge with plain integer arithmetic
   always @(posedge clk) begin : model
      int ix, iy, nx, ny;
      bit idle, sending, pend, kfire;
      if (rst) begin
         m_ax = 0; m_ay = 0; m_btn = 0; m_ls = -1000000; m_ka = 0;
         o_dx = 0; o_dy = 0; o_btn = 0; m_sat = 0;
         q.delete();
      end else begin
         ix = in_valid ? int'($signed(in_dx)) : 0;
         iy = in_valid ? int'($signed(in_dy)) : 0;
         sending = cyc == m_ls;
         nx = m_ax + ix - (sending ? o_dx : 0);
         ny = m_ay + iy - (sending ? o_dy : 0);
         if (sat16(nx) != nx || sat16(ny) != ny) m_sat = 1;
         nx = sat16(nx);
         ny = sat16(ny);
         idle = !sending && cyc >= m_ls + M - 1;
         pend = m_ax != 0 || m_ay != 0 || int'(in_buttons) != m_btn;
         kfire = 0;
`ifdef CURSOR_KEEPALIVE_EN
         kfire = idle && !pend && m_ka >= KA - 1;
         if (idle && !pend && !kfire) m_ka++;
         if (sending) m_ka = 0;
`endif
         if (idle && enable && (pend || kfire)) begin
            o_dx = pend ? clamp8(nx) : 0;
            o_dy = pend ? clamp8(ny) : 0;
            o_btn = int'(in_buttons);
            m_btn = o_btn;
            m_ls = cyc + 1;
            q.push_back('{cyc + 1, o_dx, o_dy, o_btn});
         end
         m_ax = nx;
         m_ay = ny;
      end
      cyc++;
   end

   // monitor: pops the scoreboard whenever the DUT strobes send
   always @(negedge clk) begin : monitor
      pkt_t p;
      if (!rst) begin
         if (send) begin
            if (q.size() == 0 || q[0].cyc != cyc) chk("send_timing", q.size() == 0 ? -1 : q[0].cyc, cyc);
            else begin
               p = q.pop_front();
               chk("pkt_dx", int'($signed(dx)), p.dx);
               chk("pkt_dy", int'($signed(dy)), p.dy);
               chk("pkt_buttons", int'(buttons), p.btn);
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            chk("send_missing", int'(send), 1);
            void'(q.pop_front());
         end
         chk("busy", int'(busy), int'(cyc >= m_ls && cyc <= m_ls + M - 2));
         chk("sat_flag", int'(sat_flag), int'(m_sat));
         chk("held_fields", int'({dx, dy, buttons}), int'({8'(o_dx), 8'(o_dy), 2'(o_btn)}));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("rst_send", int'(send), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sat", int'(sat_flag), 0);
      chk("rst_dx", int'(dx), 0);
      chk("rst_dy", int'(dy), 0);
      chk("rst_buttons", int'(buttons), 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 0;
   endtask

   task automatic drive(input int x, input int y);
      @(negedge clk);
      in_valid = 1;
      in_dx = 16'(x);
      in_dy = 16'(y);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 0;
      end
   endtask

   initial begin
      do_reset();
      enable = 1;
      drive(5, -3);
      idle(250);
      drive(300, 0);
      idle(400);
      @(negedge clk);
      in_buttons = 2'b01;
      idle(300);
      repeat (5) drive(30000, 0);
      idle(500);
      chk("sat_sticky", int'(sat_flag), 1);
      do_reset();
      // acc=200 emits 127 while +10 arrives in the SEND cycle; residual 83 waits for enable
      drive(200, 0);
      idle(1);
      drive(10, 0);
      @(negedge clk);
      in_valid = 0;
      enable = 0;
      idle(300);
      enable = 1;
      idle(200);
      drive(177, 0);
      idle(20);
      do_reset();
      idle(600);
      repeat (4000) begin
         @(negedge clk);
         in_valid = $urandom_range(0, 3) == 0;
         in_dx = 16'(rnd_delta());
         in_dy = 16'(rnd_delta());
         if ($urandom_range(0, 199) == 0) in_buttons = 2'($urandom_range(0, 3));
         enable = $urandom_range(0, 49) != 0;
      end
      @(negedge clk);
      in_valid = 0;
      enable = 1;
      for (int i = 0; i < 40000 && !(m_ax == 0 && m_ay == 0 && q.size() == 0 && cyc > m_ls + M); i++)
         @(negedge clk);
      chk("drain_busy", int'(busy), 0);
      chk("drain_queue", q.size(), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
